// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: control bundle
// width, bit positions inside the bundle and the all-zero NOP bundle.
package pipe_pkg;

  localparam int CTRL_W = 9;

  localparam int CTRL_REGDST   = 0;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_BRANCH   = 6;
  localparam int CTRL_ALUOP_LO = 7;
  localparam int CTRL_ALUOP_HI = 8;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_skid_slot.sv
// One holding slot of a pipeline stage: PC, payload and control plus a
// valid flag. Control is forced to NOP whenever the slot is empty so a
// bubble can never carry stray write/branch enables downstream.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int DATA_W = 96,
  parameter int CTRL_W = pipe_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              hold,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              vld,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  localparam logic [CTRL_W-1:0] NOP = CTRL_W'(CTRL_NOP);

  logic              vld_p1;
  logic [PC_W-1:0]   pc_p1;
  logic [DATA_W-1:0] data_p1;
  logic [CTRL_W-1:0] ctrl_p1;

  // Slot register: clear beats load, load beats hold, otherwise empty out.
  // PC and payload keep their last value when the slot empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      pc_p1   <= '0;
      data_p1 <= '0;
      ctrl_p1 <= NOP;
    end else if (clr) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= NOP;
    end else if (load) begin
      vld_p1  <= 1'b1;
      pc_p1   <= d_pc;
      data_p1 <= d_data;
      ctrl_p1 <= d_ctrl;
    end else if (!hold) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= NOP;
    end
  end

  assign vld  = vld_p1;
  assign pc   = pc_p1;
  assign data = data_p1;
  assign ctrl = ctrl_p1;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register (IF/ID, ID/EX, ...).
// SKID=1 adds a second slot so in_ready comes straight from a flop while
// still sustaining one beat per cycle. Flush squashes everything held and
// the beat arriving that cycle. Saturating stall/flush counters aid debug.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int DATA_W = 96,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              in_fire;
  logic              main_vld;
  logic              main_free;
  logic              main_load;
  logic              skid_vld;
  logic [PC_W-1:0]   skid_pc;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [PC_W-1:0]   main_pc_d;
  logic [DATA_W-1:0] main_data_d;
  logic [CTRL_W-1:0] main_ctrl_d;

  // Main slot can take a new beat if it is empty or its beat leaves now.
  assign main_free = ~main_vld | out_ready;
  assign in_fire   = in_valid & in_ready;

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready  = ~skid_vld;
      // A parked skid beat is older than anything upstream, so it goes first.
      assign main_load = main_free & (skid_vld | in_fire);

      pipe_skid_slot #(
        .PC_W  (PC_W),
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W)
      ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .load  (in_fire & ~main_free),
        .hold  (~main_free),
        .d_pc  (in_pc),
        .d_data(in_data),
        .d_ctrl(in_ctrl),
        .vld   (skid_vld),
        .pc    (skid_pc),
        .data  (skid_data),
        .ctrl  (skid_ctrl)
      );
    end else begin : g_noskid
      assign in_ready  = main_free;
      assign main_load = in_fire;
      assign skid_vld  = 1'b0;
      assign skid_pc   = '0;
      assign skid_data = '0;
      assign skid_ctrl = '0;
    end
  endgenerate

  assign main_pc_d   = skid_vld ? skid_pc   : in_pc;
  assign main_data_d = skid_vld ? skid_data : in_data;
  assign main_ctrl_d = skid_vld ? skid_ctrl : in_ctrl;

  pipe_skid_slot #(
    .PC_W  (PC_W),
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .load  (main_load),
    .hold  (~out_ready),
    .d_pc  (main_pc_d),
    .d_data(main_data_d),
    .d_ctrl(main_ctrl_d),
    .vld   (main_vld),
    .pc    (out_pc),
    .data  (out_data),
    .ctrl  (out_ctrl)
  );

  assign out_valid = main_vld;

  // Perf counters: stalled cycles and flushes that actually squashed a beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_vld && !out_ready && !flush) stall_cnt <= sat_inc(stall_cnt);
      if (flush && (main_vld || skid_vld || in_fire)) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a beat-queue reference model (2-deep for the
// skid build) feeds a scoreboard that a separate monitor drains on every
// presented beat; a second SKID=0 instance with 2-bit counters is checked
// with a short directed sequence.
module tb_pipe_stage_reg;

  localparam int PC_W   = 32;
  localparam int DATA_W = 96;
  localparam int CTRL_W = 9;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [PC_W-1:0]   in_pc, out_pc;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  pipe_stage_reg #(.PC_W(PC_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  logic              n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [PC_W-1:0]   n_in_pc, n_out_pc;
  logic [DATA_W-1:0] n_in_data, n_out_data;
  logic [CTRL_W-1:0] n_in_ctrl, n_out_ctrl;
  logic [1:0]        n_stall_cnt, n_flush_cnt;

  pipe_stage_reg #(.PC_W(PC_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0), .CNT_W(2)) u_ns (
    .clk(clk), .rst(rst), .flush(n_flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_pc(n_in_pc), .in_data(n_in_data), .in_ctrl(n_in_ctrl),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_pc(n_out_pc), .out_data(n_out_data),
    .out_ctrl(n_out_ctrl), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
  );

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } beat_t;

  beat_t             expq[$];
  int                occ;
  int                m_stall, m_flush;
  logic [DATA_W-1:0] last_data;
  bit                mon_en;
  int                n_chk, n_pass;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compares the presented beat against the scoreboard head and
  // pops it when downstream accepts.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      check("out_valid", out_valid, occ > 0);
      check("in_ready", in_ready, occ < 2);
      check("stall_cnt", stall_cnt, m_stall);
      check("flush_cnt", flush_cnt, m_flush);
      if (out_valid) begin
        if (expq.size() == 0) begin
          n_chk++;
          $display("FAIL scoreboard: unexpected beat pc=%0h", out_pc);
        end else begin
          check("out_pc", out_pc, expq[0].pc);
          check("out_data", out_data, expq[0].data);
          check("out_ctrl", out_ctrl, expq[0].ctrl);
          if (out_ready) begin
            last_data = expq[0].data;
            void'(expq.pop_front());
          end
        end
      end else begin
        check("bubble_ctrl", out_ctrl, 0);
        check("bubble_data", out_data, last_data);
      end
    end
  end

  // One cycle of stimulus plus the reference-model update for that edge.
  task automatic cyc(input bit v, input logic [PC_W-1:0] pc, input bit ordy, input bit fl);
    beat_t b;
    bit fi, fo;
    @(posedge clk); #1;
    b.pc   = pc;
    b.data = {$urandom, $urandom, $urandom};
    b.ctrl = CTRL_W'($urandom);
    in_valid = v; in_pc = b.pc; in_data = b.data; in_ctrl = b.ctrl;
    out_ready = ordy; flush = fl;
    @(negedge clk); #1;
    fi = v && (occ < 2);
    fo = (occ > 0) && ordy;
    if (fl) begin
      if (occ > 0 || fi) m_flush++;
      if (occ > 0 && !ordy) last_data = expq[0].data;
      occ = 0;
      expq.delete();
    end else begin
      if (occ > 0 && !ordy) m_stall++;
      occ = occ - int'(fo) + int'(fi);
      if (fi) expq.push_back(b);
    end
  endtask

  task automatic model_reset();
    occ = 0; m_stall = 0; m_flush = 0; last_data = '0;
    expq.delete();
  endtask

  initial begin
    n_chk = 0; n_pass = 0; mon_en = 0;
    model_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_data = '0; in_ctrl = '0;
    n_flush = 1'b0; n_in_valid = 1'b0; n_out_ready = 1'b1;
    n_in_pc = '0; n_in_data = '0; n_in_ctrl = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    rst = 1'b0;
    #1 check("rst_in_ready", in_ready, 1);
    mon_en = 1;

    // Back-to-back streaming, then a one-cycle bubble.
    cyc(1, 32'h00, 1, 0); cyc(1, 32'h04, 1, 0); cyc(1, 32'h08, 1, 0);
    cyc(0, 32'h0, 1, 0);  cyc(0, 32'h0, 1, 0);

    // Stall with the second beat landing in the skid slot, then release.
    cyc(1, 32'h10, 0, 0);
    cyc(0, 32'h0, 0, 0); cyc(0, 32'h0, 0, 0); cyc(0, 32'h0, 0, 0);
    cyc(1, 32'h14, 0, 0);
    cyc(0, 32'h0, 0, 0);
    cyc(0, 32'h0, 1, 0); cyc(0, 32'h0, 1, 0); cyc(0, 32'h0, 1, 0);

    // Flush with both slots full and an incoming beat; then flush of a lone in_fire.
    cyc(1, 32'h18, 0, 0); cyc(1, 32'h1c, 0, 0);
    cyc(1, 32'h20, 0, 1);
    cyc(0, 32'h0, 1, 0);
    cyc(1, 32'h24, 1, 1);
    cyc(0, 32'h0, 1, 0); cyc(0, 32'h0, 1, 1);

    // Asynchronous reset in the middle of a stalled transfer.
    cyc(1, 32'h30, 0, 0); cyc(1, 32'h34, 0, 0);
    @(posedge clk); #1;
    mon_en = 0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_ctrl", out_ctrl, 0);
    check("midrst_stall_cnt", stall_cnt, 0);
    check("midrst_flush_cnt", flush_cnt, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    #1 check("midrst_in_ready", in_ready, 1);
    mon_en = 1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    for (int i = 0; i < 4; i++) cyc(0, 32'h0, 1, 0);
    check("drained", expq.size(), 0);
    mon_en = 0;

    // SKID=0 build: combinational in_ready and 2-bit saturating stall counter.
    @(posedge clk); #1;
    n_in_valid = 1'b1; n_in_pc = 32'h40; n_in_ctrl = 9'h1ff; n_in_data = 96'h1234; n_out_ready = 1'b1;
    #1 check("ns_in_ready_empty", n_in_ready, 1);
    @(posedge clk); #1;
    n_in_valid = 1'b0; n_out_ready = 1'b0;
    #1;
    check("ns_in_ready_stall", n_in_ready, 0);
    check("ns_out_valid", n_out_valid, 1);
    check("ns_out_pc", n_out_pc, 32'h40);
    n_out_ready = 1'b1;
    #1 check("ns_in_ready_comb", n_in_ready, 1);
    n_out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("ns_stall_sat", n_stall_cnt, 3);
    check("ns_hold_pc", n_out_pc, 32'h40);
    check("ns_hold_ctrl", n_out_ctrl, 9'h1ff);
    n_flush = 1'b1;
    @(posedge clk); #1;
    n_flush = 1'b0;
    check("ns_flush_valid", n_out_valid, 0);
    check("ns_flush_ctrl", n_out_ctrl, 0);
    check("ns_flush_cnt", n_flush_cnt, 1);
    check("ns_flush_data", n_out_data, 96'h1234);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
